rotation_monitor: RTL and testbench

ROTATION_MONITOR -- requirements
Module: rotation_monitor

---
 rtl/rotation_monitor_if.sv | 23 ++
 rtl/rotation_monitor.sv | 164 ++++++++++++++++
 tb/tb_rotation_monitor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rotation_monitor_if.sv
// Sample/status bundle between a ring-tap source and rotation_monitor.
// master drives din/din_valid; slave (the monitor) drives status and dbg_state.
interface rotation_monitor_if;
  logic [6:0] din;
  logic       din_valid;
  logic       locked;
  logic [2:0] phase;
  logic [6:0] expected;
  logic       err;
  logic [7:0] err_count;
  logic [1:0] dbg_state;

  // Handshake: din is consumed on every posedge where din_valid=1; there is no
  // ready, the monitor always accepts, and status reflects it one cycle later.
  modport master (
    output din, din_valid,
    input  locked, phase, expected, err, err_count, dbg_state
  );
  modport slave (
    input  din, din_valid,
    output locked, phase, expected, err, err_count, dbg_state
  );
endinterface

// File: rtl/rotation_monitor.sv
// Locks onto a descending value ring (1,2,5,15,35,50,75,100) and flags slips.
// Define ROTATION_MONITOR_ERRCNT_EN to build the saturating err_count.
module rotation_monitor #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic               clk,
  input  logic               reset,
  rotation_monitor_if.slave  mon
);

  typedef enum logic [1:0] {HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] LOCK_LIM   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_CNT);

  function automatic logic [6:0] tbl(input logic [2:0] idx);
    logic [6:0] v;
    unique case (idx)
      3'd0: v = 7'd1;
      3'd1: v = 7'd2;
      3'd2: v = 7'd5;
      3'd3: v = 7'd15;
      3'd4: v = 7'd35;
      3'd5: v = 7'd50;
      3'd6: v = 7'd75;
      default: v = 7'd100;
    endcase
    return v;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [2:0] match_q, match_d;
  logic [2:0] miss_q, miss_d;
  logic       locked_q, locked_d;
  logic [6:0] expected_q, expected_d;
  logic       err_q, err_d;

  logic       hit;
  logic [2:0] hit_idx;
  logic [2:0] prev_idx;
  logic [2:0] next_prev_idx;
  logic       ring_hit;
  logic [3:0] match_inc;
  logic [3:0] miss_inc;

  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mon.din == tbl(3'(i))) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // The ring runs downward through the table, so the successor is index-1 (mod 8).
  assign prev_idx  = phase_q - 3'd1;
  assign ring_hit  = (mon.din == tbl(prev_idx));
  assign match_inc = {1'b0, match_q} + 4'd1;
  assign miss_inc  = {1'b0, miss_q} + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      phase_q    <= 3'd0;
      match_q    <= 3'd0;
      miss_q     <= 3'd0;
      locked_q   <= 1'b0;
      expected_q <= 7'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      locked_q   <= locked_d;
      expected_q <= expected_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (mon.din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (hit) begin
            state_d = CONFIRM;
            phase_d = hit_idx;
            match_d = 3'd1;
          end
        end
        CONFIRM: begin
          if (hit && (hit_idx == prev_idx)) begin
            phase_d = prev_idx;
            match_d = match_inc[2:0];
            if (match_inc >= LOCK_LIM) begin
              state_d = LOCKED;
              match_d = 3'd0;
              miss_d  = 3'd0;
            end
          end else if (hit) begin
            phase_d = hit_idx;
            match_d = 3'd1;
          end else begin
            state_d = HUNT;
            match_d = 3'd0;
          end
        end
        LOCKED: begin
          if (ring_hit) begin
            phase_d = prev_idx;
            miss_d  = 3'd0;
          end else if (miss_inc >= UNLOCK_LIM) begin
            // Losing lock freezes phase at the last flywheel position.
            state_d = HUNT;
            miss_d  = 3'd0;
          end else begin
            phase_d = prev_idx;
            miss_d  = miss_inc[2:0];
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign next_prev_idx = phase_d - 3'd1;

  always_comb begin
    locked_d   = (state_d == LOCKED);
    expected_d = locked_d ? tbl(next_prev_idx) : 7'd0;
    err_d      = mon.din_valid && (state_q == LOCKED) && !ring_hit;
  end

  assign mon.locked    = locked_q;
  assign mon.phase     = phase_q;
  assign mon.expected  = expected_q;
  assign mon.err       = err_q;
  assign mon.dbg_state = state_q;

`ifdef ROTATION_MONITOR_ERRCNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= 8'd0;
    end else if (err_d && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign mon.err_count = err_count_q;
`else
  assign mon.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_rotation_monitor.sv
// Directed bench for rotation_monitor: vector table plus reset/saturation sequences.
module tb_rotation_monitor;

  localparam int NV = 31;

  typedef struct {
    logic       v;
    logic [6:0] din;
    logic       lk;
    logic [2:0] ph;
    logic [6:0] ex;
    logic       er;
    logic [7:0] ec;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [6:0] ring [8];
  logic [19:0] exp_q[$];
  vec_t vecs [NV];

  rotation_monitor_if mif();

  rotation_monitor #(.LOCK_CNT(3), .UNLOCK_CNT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ec_exp(input logic [7:0] v);
`ifdef ROTATION_MONITOR_ERRCNT_EN
    return v;
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] d);
    @(negedge clk);
    mif.din_valid = v;
    mif.din       = d;
    @(posedge clk);
    #1;
  endtask

  // Pops one expected record and compares every status output against it.
  task automatic check_all(input string tag);
    logic [19:0] e;
    e = exp_q.pop_front();
    chk({tag, ".locked"},    int'(mif.locked),    int'(e[19]));
    chk({tag, ".phase"},     int'(mif.phase),     int'(e[18:16]));
    chk({tag, ".expected"},  int'(mif.expected),  int'(e[15:9]));
    chk({tag, ".err"},       int'(mif.err),       int'(e[8]));
    chk({tag, ".err_count"}, int'(mif.err_count), int'(e[7:0]));
  endtask

  task automatic step(input string tag, input logic v, input logic [6:0] d,
                      input logic lk, input logic [2:0] ph, input logic [6:0] ex,
                      input logic er, input logic [7:0] ec);
    drive(v, d);
    exp_q.push_back({lk, ph, ex, er, ec_exp(ec)});
    check_all(tag);
  endtask

  initial begin
    ring = '{7'd1, 7'd2, 7'd5, 7'd15, 7'd35, 7'd50, 7'd75, 7'd100};
    //            v   din    lk  ph   ex      er  ec
    vecs[0]  = '{1'b1, 7'd1,   1'b0, 3'd0, 7'd0,   1'b0, 8'd0};
    vecs[1]  = '{1'b1, 7'd100, 1'b0, 3'd7, 7'd0,   1'b0, 8'd0};
    vecs[2]  = '{1'b1, 7'd75,  1'b1, 3'd6, 7'd50,  1'b0, 8'd0};
    vecs[3]  = '{1'b0, 7'd35,  1'b1, 3'd6, 7'd50,  1'b0, 8'd0};
    vecs[4]  = '{1'b1, 7'd35,  1'b1, 3'd5, 7'd35,  1'b1, 8'd1};
    vecs[5]  = '{1'b1, 7'd35,  1'b1, 3'd4, 7'd15,  1'b0, 8'd1};
    vecs[6]  = '{1'b1, 7'd7,   1'b1, 3'd3, 7'd5,   1'b1, 8'd2};
    vecs[7]  = '{1'b1, 7'd7,   1'b0, 3'd3, 7'd0,   1'b1, 8'd3};
    vecs[8]  = '{1'b1, 7'd7,   1'b0, 3'd3, 7'd0,   1'b0, 8'd3};
    vecs[9]  = '{1'b1, 7'd5,   1'b0, 3'd2, 7'd0,   1'b0, 8'd3};
    vecs[10] = '{1'b0, 7'd99,  1'b0, 3'd2, 7'd0,   1'b0, 8'd3};
    vecs[11] = '{1'b1, 7'd2,   1'b0, 3'd1, 7'd0,   1'b0, 8'd3};
    vecs[12] = '{1'b0, 7'd1,   1'b0, 3'd1, 7'd0,   1'b0, 8'd3};
    vecs[13] = '{1'b0, 7'd1,   1'b0, 3'd1, 7'd0,   1'b0, 8'd3};
    vecs[14] = '{1'b1, 7'd100, 1'b0, 3'd7, 7'd0,   1'b0, 8'd3};
    vecs[15] = '{1'b1, 7'd75,  1'b0, 3'd6, 7'd0,   1'b0, 8'd3};
    vecs[16] = '{1'b0, 7'd50,  1'b0, 3'd6, 7'd0,   1'b0, 8'd3};
    vecs[17] = '{1'b1, 7'd50,  1'b1, 3'd5, 7'd35,  1'b0, 8'd3};
    vecs[18] = '{1'b1, 7'd35,  1'b1, 3'd4, 7'd15,  1'b0, 8'd3};
    vecs[19] = '{1'b1, 7'd15,  1'b1, 3'd3, 7'd5,   1'b0, 8'd3};
    vecs[20] = '{1'b1, 7'd99,  1'b1, 3'd2, 7'd2,   1'b1, 8'd4};
    vecs[21] = '{1'b1, 7'd2,   1'b1, 3'd1, 7'd1,   1'b0, 8'd4};
    vecs[22] = '{1'b1, 7'd1,   1'b1, 3'd0, 7'd100, 1'b0, 8'd4};
    vecs[23] = '{1'b1, 7'd100, 1'b1, 3'd7, 7'd75,  1'b0, 8'd4};
    vecs[24] = '{1'b1, 7'd3,   1'b1, 3'd6, 7'd50,  1'b1, 8'd5};
    vecs[25] = '{1'b1, 7'd3,   1'b0, 3'd6, 7'd0,   1'b1, 8'd6};
    vecs[26] = '{1'b1, 7'd15,  1'b0, 3'd3, 7'd0,   1'b0, 8'd6};
    vecs[27] = '{1'b1, 7'd9,   1'b0, 3'd3, 7'd0,   1'b0, 8'd6};
    vecs[28] = '{1'b1, 7'd5,   1'b0, 3'd2, 7'd0,   1'b0, 8'd6};
    vecs[29] = '{1'b1, 7'd2,   1'b0, 3'd1, 7'd0,   1'b0, 8'd6};
    vecs[30] = '{1'b1, 7'd1,   1'b1, 3'd0, 7'd100, 1'b0, 8'd6};

    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    mif.din_valid = 1'b1;
    mif.din       = 7'($urandom_range(0, 127));

    // Reset held with random valid samples: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mif.din = 7'($urandom_range(0, 127));
      @(posedge clk);
      #1;
      exp_q.push_back(20'd0);
      check_all($sformatf("rst%0d", i));
      chk($sformatf("rst%0d.state", i), int'(mif.dbg_state), 0);
    end
    @(negedge clk);
    mif.din_valid = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].din);
      exp_q.push_back({vecs[i].lk, vecs[i].ph, vecs[i].ex, vecs[i].er, ec_exp(vecs[i].ec)});
      check_all($sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges while locked.
    @(negedge clk);
    mif.din_valid = 1'b0;
    reset = 1'b0;
    #1;
    exp_q.push_back(20'd0);
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    step("relock0", 1'b1, 7'd1,   1'b0, 3'd0, 7'd0,  1'b0, 8'd0);
    step("relock1", 1'b1, 7'd100, 1'b0, 3'd7, 7'd0,  1'b0, 8'd0);
    step("relock2", 1'b1, 7'd75,  1'b1, 3'd6, 7'd50, 1'b0, 8'd0);

    // Alternate a slip and a correct sample so lock holds across 255 errors.
    begin
      logic [2:0] ph;
      ph = 3'd6;
      for (int i = 0; i < 255; i++) begin
        drive(1'b1, 7'd99);
        ph = ph - 3'd1;
        chk("sat_err", int'(mif.err), 1);
        drive(1'b1, ring[ph - 3'd1]);
        ph = ph - 3'd1;
      end
      chk("sat_locked", int'(mif.locked), 1);
      chk("sat_phase", int'(mif.phase), int'(ph));
      chk("sat_count", int'(mif.err_count), int'(ec_exp(8'd255)));
      drive(1'b1, 7'd99);
      ph = ph - 3'd1;
      chk("sat_over_err", int'(mif.err), 1);
      chk("sat_over_count", int'(mif.err_count), int'(ec_exp(8'd255)));
      chk("sat_over_locked", int'(mif.locked), 1);
      chk("sat_over_expected", int'(mif.expected), int'(ring[ph - 3'd1]));
      drive(1'b0, 7'd0);
      chk("sat_pulse_end", int'(mif.err), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
